scan_sel_sequencer: RTL and testbench



---
 rtl/scan_sel_sequencer_pkg.sv | 16 +
 rtl/scan_sel_sequencer_if.sv | 34 +++
 rtl/scan_sel_sequencer_next_chan_find.sv | 42 ++++
 rtl/scan_sel_sequencer.sv | 140 ++++++++++++++
 tb/tb_scan_sel_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_sel_sequencer_pkg.sv
// Shared definitions for the scan select sequencer.
//   - scan state enum (IDLE / DWELL / GAP)
//   - default select width, channel count and dwell-counter width
package scan_pkg;

    localparam int SEL_W_DEF = 4;
    localparam int N_CH_DEF  = 2 ** SEL_W_DEF;
    localparam int DW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sel_sequencer_if.sv
// Control/status bundle between a scan controller and scan_sel_sequencer.
//   master : drives start, stop, mode_cont, chan_mask, dwell;
//            observes sel, sel_valid, busy, wrap, done
//   slave  : the sequencer side (mirror of master)
interface scan_sel_sequencer_if
    import scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DW    = DW_DEF
);
    localparam int N_CH = 2 ** SEL_W;

    logic             start;
    logic             stop;
    logic             mode_cont;
    logic [N_CH-1:0]  chan_mask;
    logic [DW-1:0]    dwell;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic             wrap;
    logic             done;

    modport master (
        output start, stop, mode_cont, chan_mask, dwell,
        input  sel, sel_valid, busy, wrap, done
    );

    modport slave (
        input  start, stop, mode_cont, chan_mask, dwell,
        output sel, sel_valid, busy, wrap, done
    );

endinterface

// File: rtl/scan_sel_sequencer_next_chan_find.sv
// Combinational channel search over an enable mask.
//   mask        : channel enable bits
//   cur         : current channel index
//   found_above : some enabled channel has an index strictly above cur
//   idx_above   : lowest such index (0 when none)
//   found_any   : mask is non-zero
//   idx_lowest  : lowest enabled index (0 when none)
module next_chan_find
    import scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [2**SEL_W-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic                found_above,
    output logic [SEL_W-1:0]    idx_above,
    output logic                found_any,
    output logic [SEL_W-1:0]    idx_lowest
);
    localparam int N_CH = 2 ** SEL_W;

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves a combinational output unassigned infers a latch.
        found_above = 1'b0;
        idx_above   = '0;
        found_any   = 1'b0;
        idx_lowest  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found_any  = 1'b1;
                idx_lowest = SEL_W'(i);
                if (i > int'(cur)) begin
                    found_above = 1'b1;
                    idx_above   = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Sequential select/enable source for a 4:16 one-hot decoder.
// Walks the enabled channels of a mask captured at start, holding each for
// dwell+1 cycles, with a one-cycle break-before-make gap between channels.
// One-shot or continuous (wrap) operation; stop ends the scan at the next gap.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of scan_sel_sequencer_if (start/stop/config in,
//           sel/sel_valid/busy/wrap/done out, all registered)
module scan_sel_sequencer
    import scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scan_sel_sequencer_if.slave   bus
);
    localparam int N_CH = 2 ** SEL_W;

    state_t           state, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             cont_q, cont_d;
    logic [DW-1:0]    cnt, cnt_d;
    logic             stop_pend, stop_pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, busy_q, wrap_q, done_q;
    logic             wrap_d, done_d;

    logic [N_CH-1:0]  find_mask;
    logic             found_above, found_any;
    logic [SEL_W-1:0] idx_above, idx_lowest;

    // In IDLE the search must look at the live mask, since capture happens
    // on the same edge that enters the first DWELL.
    assign find_mask = (state == IDLE) ? bus.chan_mask : mask_q;

    next_chan_find #(.SEL_W(SEL_W)) u_find (
        .mask        (find_mask),
        .cur         (sel_q),
        .found_above (found_above),
        .idx_above   (idx_above),
        .found_any   (found_any),
        .idx_lowest  (idx_lowest)
    );

    always_comb begin
        state_d     = state;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        cnt_d       = cnt;
        stop_pend_d = stop_pend;
        sel_d       = sel_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (bus.start) begin
                    if (found_any) begin
                        mask_d  = bus.chan_mask;
                        dwell_d = bus.dwell;
                        cont_d  = bus.mode_cont;
                        cnt_d   = bus.dwell;
                        sel_d   = idx_lowest;
                        state_d = DWELL;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (bus.stop) stop_pend_d = 1'b1;
                if (cnt == '0) state_d = GAP;
                else           cnt_d   = cnt - DW'(1);
            end
            GAP: begin
                // A stop seen in this very cycle ends the scan here too.
                if (stop_pend || bus.stop) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (found_above) begin
                    state_d = DWELL;
                    sel_d   = idx_above;
                    cnt_d   = dwell_q;
                end else if (cont_q) begin
                    state_d = DWELL;
                    sel_d   = idx_lowest;
                    cnt_d   = dwell_q;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            cnt         <= '0;
            stop_pend   <= 1'b0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            cnt         <= cnt_d;
            stop_pend   <= stop_pend_d;
            sel_q       <= sel_d;
            sel_valid_q <= (state_d == DWELL);
            busy_q      <= (state_d != IDLE);
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.wrap      = wrap_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Self-checking bench for scan_sel_sequencer: a table of scenarios with
// hand-derived busy/wrap totals, randomized scenarios, and hand-written
// reset / IDLE-handshake sequences, all checked cycle by cycle against a
// trace built from the scan rules.
module tb_scan_sel_sequencer;

    typedef struct packed {
        logic [3:0] sel;
        logic       sel_valid;
        logic       busy;
        logic       wrap;
        logic       done;
    } rec_t;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  dwell;
        logic        cont;
        int          stop_at;
        int          exp_busy;
        int          exp_wraps;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    rec_t exp_q[$];

    scan_sel_sequencer_if bus ();

    scan_sel_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected output trace of one scan, one entry per cycle after the start
    // edge: each enabled channel in ascending order for dwell+1 valid cycles,
    // then a gap; a pass ends after the highest channel. stop seen while
    // entry stop_at is showing ends the scan at the first gap at or after it.
    function automatic void build_trace(input logic [15:0] mask, input logic [7:0] dw,
                                        input logic cont, input int stop_at);
        rec_t r;
        int   pass;
        bit   first;
        exp_q.delete();
        r = '0;
        if (mask == 16'h0) begin
            r.done = 1'b1;
            exp_q.push_back(r);
            return;
        end
        pass = 0;
        while (exp_q.size() < 4000) begin
            first = 1'b1;
            for (int ch = 0; ch < 16; ch++) begin
                if (mask[ch]) begin
                    for (int d = 0; d <= int'(dw); d++) begin
                        r = '0;
                        r.sel = 4'(ch);
                        r.sel_valid = 1'b1;
                        r.busy = 1'b1;
                        r.wrap = (d == 0) && first && (pass > 0);
                        exp_q.push_back(r);
                    end
                    first = 1'b0;
                    r = '0;
                    r.sel = 4'(ch);
                    r.busy = 1'b1;
                    exp_q.push_back(r);
                    if (stop_at >= 0 && stop_at <= exp_q.size() - 1) begin
                        r = '0;
                        r.done = 1'b1;
                        exp_q.push_back(r);
                        return;
                    end
                end
            end
            if (!cont) begin
                r = '0;
                r.done = 1'b1;
                exp_q.push_back(r);
                return;
            end
            pass++;
        end
    endfunction

    function automatic rec_t sample();
        rec_t a;
        a.sel       = bus.sel;
        a.sel_valid = bus.sel_valid;
        a.busy      = bus.busy;
        a.wrap      = bus.wrap;
        a.done      = bus.done;
        return a;
    endfunction

    // Runs one scan and compares every cycle. While busy, the captured inputs
    // are scrambled and start is pulsed randomly; neither may matter.
    task automatic run_scan(input logic [15:0] mask, input logic [7:0] dw, input logic cont,
                            input int stop_at, input logic stop_with_start,
                            output int busy_cnt, output int wraps);
        rec_t act, exp;
        build_trace(mask, dw, cont, stop_at);
        busy_cnt = 0;
        wraps    = 0;
        bus.chan_mask = mask;
        bus.dwell     = dw;
        bus.mode_cont = cont;
        bus.start     = 1'b1;
        bus.stop      = stop_with_start;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            exp = exp_q[k];
            act = sample();
            if (!exp.busy) begin
                act.sel = '0;
                exp.sel = '0;
            end
            check($sformatf("trace m=%h d=%0d c=%0d k=%0d", mask, dw, cont, k), 32'(act), 32'(exp));
            busy_cnt += int'(bus.busy);
            wraps    += int'(bus.wrap);
            bus.chan_mask = 16'($urandom);
            bus.dwell     = 8'($urandom);
            bus.mode_cont = 1'($urandom);
            bus.start     = exp.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.stop      = (k == stop_at);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        act = sample();
        act.sel = '0;
        check("idle after scan", 32'(act), 32'(0));
    endtask

    vec_t vecs[10];
    int   busy_cnt, wraps;
    rec_t act;

    initial begin
        //          mask      dwell  cont  stop_at busy wraps
        vecs[0] = '{16'h0005, 8'd2,   1'b0, -1,  8,   0};
        vecs[1] = '{16'hFFFF, 8'd0,   1'b0, -1,  32,  0};
        vecs[2] = '{16'h0000, 8'd3,   1'b0, -1,  0,   0};
        vecs[3] = '{16'h0040, 8'd3,   1'b0, -1,  5,   0};
        vecs[4] = '{16'h8001, 8'd0,   1'b1, 14,  16,  3};
        vecs[5] = '{16'h0100, 8'd1,   1'b1, 0,   3,   0};
        vecs[6] = '{16'h0100, 8'd1,   1'b1, 2,   3,   0};
        vecs[7] = '{16'h0100, 8'd1,   1'b1, 3,   6,   1};
        vecs[8] = '{16'h8000, 8'd255, 1'b0, -1,  257, 0};
        vecs[9] = '{16'h000A, 8'd1,   1'b0, -1,  6,   0};

        n_tests = 0;
        n_fail  = 0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mode_cont = 1'b0;
        bus.chan_mask = '0;
        bus.dwell = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'(sample()), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_scan(vecs[i].mask, vecs[i].dwell, vecs[i].cont, vecs[i].stop_at, 1'b0, busy_cnt, wraps);
            check($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d wraps", i), 32'(wraps), 32'(vecs[i].exp_wraps));
        end

        // start and stop together in IDLE: the scan starts normally.
        run_scan(16'h0005, 8'd2, 1'b0, -1, 1'b1, busy_cnt, wraps);
        check("start+stop busy", 32'(busy_cnt), 32'd8);

        // stop alone in IDLE is ignored and leaves no pending stop behind.
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        act = sample();
        act.sel = '0;
        check("stop in idle", 32'(act), 32'(0));
        run_scan(16'h0011, 8'd1, 1'b0, -1, 1'b0, busy_cnt, wraps);
        check("scan after idle stop", 32'(busy_cnt), 32'd6);

        // Asynchronous reset mid-DWELL on channel 6.
        bus.chan_mask = 16'h0040;
        bus.dwell     = 8'd10;
        bus.mode_cont = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-reset sel", 32'(bus.sel), 32'd6);
        check("pre-reset valid", 32'(bus.sel_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'(sample()), 32'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no done after reset", 32'(sample()), 32'(0));
        end
        run_scan(16'h0040, 8'd1, 1'b0, -1, 1'b0, busy_cnt, wraps);
        check("post-reset scan busy", 32'(busy_cnt), 32'd3);

        // Randomized scans against the trace model.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] m;
            logic [7:0]  d;
            logic        c;
            int          s;
            m = 16'($urandom);
            if ($urandom_range(0, 1) == 1) m = m & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 9) == 0) m = 16'h0;
            d = 8'($urandom_range(0, 4));
            c = 1'($urandom_range(0, 1));
            s = c ? int'($urandom_range(0, 60)) : (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1);
            run_scan(m, d, c, s, 1'($urandom_range(0, 1)), busy_cnt, wraps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
